sl_transmitter: RTL and testbench
=================================

# sl_transmitter

Serial-line (SL) frame transmitter: the sending end of the two-wire SL link already decoded by `SL_receiver`. It accepts a configuration word and a data word, and serialises the data LSB-first as return-to-one pulses on separate "zeroes" and "ones" lines. Each frame ends with per-line parity bits and an end marker. It sits beside the receiver on the same register/clock domain and drives the loopback or external SL pins.

## Interface

Parameters:
- `BASE_HALF_CYCLES`, default 4: clocks in one unit U (= half pulse width) at `freq_sel`=0.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_enable`  in  1  one-cycle strobe: load `wr_config_w`.
- `wr_config_w`  in  16  [0]=`par_inv` (send inverted parity), [6:1]=`length`, [8:7]=`freq_sel`, [15:9] ignored.
- `r_config_w`  out  16  current accepted config, unused bits 0.
- `data_w`  in  32  word to send, captured on accept.
- `send_valid`  in  1  request to send `data_w`.
- `send_ready`  out  1  high in IDLE; accept = `send_valid & send_ready`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.
- `cfg_error`  out  1  sticky: rejected config write; cleared by next accepted write.
- `serial_line_zeroes`  out  1  SL zero line, idle 1.
- `serial_line_ones`  out  1  SL one line, idle 1.

## Operation

- Config valid iff `length` even and 8..32. Valid write in IDLE: loads `r_config_w`, clears `cfg_error`. Invalid write or any write while `busy`: config unchanged, `cfg_error`=1.
- U = `BASE_HALF_CYCLES << freq_sel` clocks. A 16-bit unit counter plus a phase counter time all states.
- FSM: IDLE -> DATA -> GAP -> PARITY -> SEP -> STOP -> TAIL -> IDLE.
- DATA, per bit i=0..length-1, 4U each: 1U both high; 2U selected line low (`zeroes` if bit=0, `ones` if bit=1), other line high; 1U both high.
- GAP: 1U both high.
- PARITY, 2U: `zeroes` = p0 ^ `par_inv`, `ones` = p1 ^ `par_inv`. p0 is initialised to 1 at accept and toggles per 0 bit sent. p1 is initialised to 0 and toggles per 1 bit sent.
- SEP: 2U both high. STOP: 2U both low. TAIL: 1U both high.
- Frame length = (4·length + 8)·U clocks.
- Data shift register is 32 bits, shifted right per bit. Bits above `length` are never sent. Bit counter is 6 bits.
- Config is snapshotted at accept. Writes during a frame never alter it (they are rejected per above).

## Timing

- Reset values: `serial_line_zeroes`=1, `serial_line_ones`=1, `busy`=0, `done`=0, `send_ready`=0 during the reset cycle then 1, `cfg_error`=0, `r_config_w`=16'h0010 (length 8, freq_sel 0, par_inv 0).
- Line outputs are registered.
- Accept on edge E0: `busy`=1 and `send_ready`=0 from E0. The first DATA unit occupies clocks E0+1..E0+U.
- Last TAIL clock ends at E0+(4·length+8)·U. `done` is high the following cycle, together with `busy`=0 and `send_ready`=1.
- A new frame may be accepted in the same cycle `done` is high; back-to-back frames are separated only by the TAIL unit.
- `send_valid` while `busy` is ignored (no queueing); it is held by the requester.
- `rst` mid-frame: next edge returns all outputs to reset values, including both lines to 1. No partial parity or stop is sent.
- `wr_enable` and accept in the same IDLE cycle: the config write takes effect first, and the frame uses the new config if valid.

## Test plan

- Reset, then length 8, freq_sel 0, U=4, send 0xA5:
  - `ones` low clocks 5..12 after accept (bit0=1); `zeroes` low clocks 21..28 (bit1=0).
  - Parity window: `zeroes`=1, `ones`=0.
  - STOP both low for 8 clocks.
  - `done` pulse at clock 161.
- Length 32, freq_sel 2 (U=16), data 0xFFFFFFFF: no pulses on `zeroes`; parity `zeroes`=1, `ones`=0; frame 136·16 = 2176 clocks.
- Same 0xA5 frame with `par_inv`=1: parity `zeroes`=0, `ones`=1; all other waveform timing identical to scenario 1.
- Config writes: length 7 -> `cfg_error`=1, `r_config_w` unchanged. Length 34 -> rejected. Length 20 during a frame -> rejected, and the running frame keeps its length. Length 20 in IDLE -> accepted, `cfg_error`=0.
- Three back-to-back frames with `send_valid` held high: each accepted in its `done` cycle; loopback into `SL_receiver` yields matching `data_w` and status 16'b1000 for each frame.
- Assert `rst` mid-DATA while `ones` is low: both lines 1 and `busy`=0 next edge. A subsequent frame of length 8 completes normally.

Source files
------------

// File: rtl/sl_transmitter.sv
// Serial-line (SL) frame transmitter: sends a data word LSB-first as return-to-one
// pulses on separate zeroes/ones lines, followed by parity, separator, stop and tail.
`timescale 1ns/1ps
module sl_transmitter #(
  parameter int unsigned BASE_HALF_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_enable,
  input  logic [15:0] wr_config_w,
  output logic [15:0] r_config_w,
  input  logic [31:0] data_w,
  input  logic        send_valid,
  output logic        send_ready,
  output logic        busy,
  output logic        done,
  output logic        cfg_error,
  output logic        serial_line_zeroes,
  output logic        serial_line_ones
);

  localparam int unsigned LEN_W  = 6;
  localparam int unsigned UNIT_W = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_SEP    = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_TAIL   = 3'd6;

  logic [2:0]        state, state_n;
  logic [UNIT_W-1:0] unit_cnt, unit_n;
  logic [UNIT_W-1:0] u_last, u_last_n;
  logic [1:0]        phase, phase_n;
  logic [LEN_W-1:0]  bit_cnt, bit_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [31:0]       sreg, sreg_n;
  logic              p0, p0_n, p1, p1_n, inv_q, inv_n;
  logic [15:0]       cfg_n;
  logic              err_n, ready_n, busy_n, done_n, z_n, o_n;
  logic              wr_ok, unit_end;
  logic [LEN_W-1:0]  wr_len;
  logic              unused_cfg_bits;

  assign unused_cfg_bits = ^wr_config_w[15:9];
  assign wr_len = wr_config_w[6:1];

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      unit_cnt           <= '0;
      u_last             <= UNIT_W'(BASE_HALF_CYCLES) - 16'd1;
      phase              <= '0;
      bit_cnt            <= '0;
      len_q              <= 6'd8;
      sreg               <= '0;
      p0                 <= 1'b1;
      p1                 <= 1'b0;
      inv_q              <= 1'b0;
      r_config_w         <= 16'h0010;
      cfg_error          <= 1'b0;
      send_ready         <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      serial_line_zeroes <= 1'b1;
      serial_line_ones   <= 1'b1;
    end else begin
      state              <= state_n;
      unit_cnt           <= unit_n;
      u_last             <= u_last_n;
      phase              <= phase_n;
      bit_cnt            <= bit_n;
      len_q              <= len_n;
      sreg               <= sreg_n;
      p0                 <= p0_n;
      p1                 <= p1_n;
      inv_q              <= inv_n;
      r_config_w         <= cfg_n;
      cfg_error          <= err_n;
      send_ready         <= ready_n;
      busy               <= busy_n;
      done               <= done_n;
      serial_line_zeroes <= z_n;
      serial_line_ones   <= o_n;
    end
  end

  // Next position in the frame; line levels are derived from that next position
  always_comb begin
    state_n  = state;
    unit_n   = unit_cnt;
    u_last_n = u_last;
    phase_n  = phase;
    bit_n    = bit_cnt;
    len_n    = len_q;
    sreg_n   = sreg;
    p0_n     = p0;
    p1_n     = p1;
    inv_n    = inv_q;
    cfg_n    = r_config_w;
    err_n    = cfg_error;
    ready_n  = send_ready;
    busy_n   = busy;
    done_n   = 1'b0;
    z_n      = 1'b1;
    o_n      = 1'b1;
    wr_ok    = !wr_len[0] && (wr_len >= 6'd8) && (wr_len <= 6'd32);
    unit_end = (unit_cnt == u_last);

    if (wr_enable) begin
      if (state == S_IDLE && wr_ok) begin
        cfg_n = {7'd0, wr_config_w[8:0]};
        err_n = 1'b0;
      end else begin
        err_n = 1'b1;
      end
    end

    if (state == S_IDLE) begin
      ready_n = 1'b1;
      busy_n  = 1'b0;
      // cfg_n already holds a same-cycle valid write, so the frame picks it up
      if (send_valid && send_ready) begin
        state_n  = S_DATA;
        unit_n   = '0;
        phase_n  = '0;
        bit_n    = '0;
        sreg_n   = data_w;
        p0_n     = 1'b1;
        p1_n     = 1'b0;
        len_n    = cfg_n[6:1];
        inv_n    = cfg_n[0];
        u_last_n = UNIT_W'(BASE_HALF_CYCLES << cfg_n[8:7]) - 16'd1;
        ready_n  = 1'b0;
        busy_n   = 1'b1;
      end
    end else if (!unit_end) begin
      unit_n = unit_cnt + 16'd1;
    end else begin
      unit_n  = '0;
      phase_n = phase + 2'd1;
      case (state)
        S_DATA: begin
          if (phase == 2'd3) begin
            phase_n = '0;
            p0_n    = p0 ^ ~sreg[0];
            p1_n    = p1 ^ sreg[0];
            sreg_n  = sreg >> 1;
            if (bit_cnt == len_q - 6'd1) state_n = S_GAP;
            else bit_n = bit_cnt + 6'd1;
          end
        end
        S_GAP: begin
          phase_n = '0;
          state_n = S_PARITY;
        end
        S_PARITY: if (phase == 2'd1) begin phase_n = '0; state_n = S_SEP;  end
        S_SEP:    if (phase == 2'd1) begin phase_n = '0; state_n = S_STOP; end
        S_STOP:   if (phase == 2'd1) begin phase_n = '0; state_n = S_TAIL; end
        S_TAIL: begin
          phase_n = '0;
          state_n = S_IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          ready_n = 1'b1;
        end
        default: begin
          phase_n = '0;
          state_n = S_IDLE;
          busy_n  = 1'b0;
          ready_n = 1'b1;
        end
      endcase
    end

    case (state_n)
      S_DATA: begin
        if (phase_n == 2'd1 || phase_n == 2'd2) begin
          if (sreg_n[0]) o_n = 1'b0;
          else z_n = 1'b0;
        end
      end
      S_PARITY: begin
        z_n = p0_n ^ inv_n;
        o_n = p1_n ^ inv_n;
      end
      S_STOP: begin
        z_n = 1'b0;
        o_n = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sl_transmitter.sv
// Self-checking bench for sl_transmitter: a scoreboard of expected frames is checked
// cycle by cycle against the SL lines, with scenario tasks checking control/status.
`timescale 1ns/1ps
module tb_sl_transmitter;

  localparam int unsigned BASE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_enable = 1'b0;
  logic [15:0] wr_config_w = '0;
  logic [15:0] r_config_w;
  logic [31:0] data_w = '0;
  logic        send_valid = 1'b0;
  logic        send_ready, busy, done, cfg_error;
  logic        serial_line_zeroes, serial_line_ones;

  always #5 clk = ~clk;

  sl_transmitter #(.BASE_HALF_CYCLES(BASE)) dut (
    .clk(clk), .rst(rst), .wr_enable(wr_enable), .wr_config_w(wr_config_w),
    .r_config_w(r_config_w), .data_w(data_w), .send_valid(send_valid),
    .send_ready(send_ready), .busy(busy), .done(done), .cfg_error(cfg_error),
    .serial_line_zeroes(serial_line_zeroes), .serial_line_ones(serial_line_ones)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned len;
    int unsigned fs;
    logic        inv;
  } frame_t;

  frame_t exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int frames_done = 0;
  int frames_aborted = 0;

  function automatic frame_t mk(logic [31:0] d, int unsigned len, int unsigned fs, logic inv);
    frame_t f;
    f.data = d; f.len = len; f.fs = fs; f.inv = inv;
    return f;
  endfunction

  function automatic logic [15:0] cfg_word(int unsigned len, int unsigned fs, logic inv);
    return {7'd0, 2'(fs), 6'(len), inv};
  endfunction

  // Expected {zeroes, ones} for clock k (1-based) of a frame, from the frame format
  function automatic logic [1:0] exp_line(frame_t f, int unsigned k);
    int unsigned uu, u, zc, oc;
    logic b;
    uu = BASE << f.fs;
    u = (k - 1) / uu;
    if (u < 4 * f.len) begin
      b = f.data[5'(u / 4)];
      if (u % 4 == 1 || u % 4 == 2) return b ? 2'b10 : 2'b01;
      return 2'b11;
    end
    u = u - 4 * f.len;
    zc = 0; oc = 0;
    for (int i = 0; i < int'(f.len); i++) if (f.data[i]) oc++; else zc++;
    case (u)
      1, 2:    return {~zc[0] ^ f.inv, oc[0] ^ f.inv};
      5, 6:    return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  // Scoreboard: on every accept pop the expected frame and compare each line clock
  initial begin : monitor
    frame_t f;
    int unsigned n, bad, first;
    logic [1:0] got, exp_v, fgot, fexp;
    bit aborted;
    forever begin
      @(posedge clk);
      if (!rst && send_valid && send_ready) begin
        if (exp_q.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL unexpected_accept: got accept, required none queued");
        end else begin
          f = exp_q.pop_front();
          n = (4 * f.len + 8) * (BASE << f.fs);
          bad = 0; first = 0; aborted = 0; fgot = '0; fexp = '0;
          for (int unsigned k = 1; k <= n; k++) begin
            if (k > 1) begin
              @(posedge clk);
              if (rst) begin aborted = 1; break; end
            end
            #1;
            got = {serial_line_zeroes, serial_line_ones};
            exp_v = exp_line(f, k);
            if (got !== exp_v) begin
              if (bad == 0) begin first = k; fgot = got; fexp = exp_v; end
              bad++;
            end
          end
          if (aborted) begin
            frames_aborted++;
          end else begin
            n_assert++;
            if (bad != 0) begin
              n_fail++;
              $display("FAIL frame_wave data=%h len=%0d: clock %0d got %b required %b (%0d bad clocks)",
                       f.data, f.len, first, fgot, fexp, bad);
            end
            @(posedge clk); #1;
            n_assert++;
            if ({done, busy, send_ready} !== 3'b101) begin
              n_fail++;
              $display("FAIL frame_end data=%h: got done/busy/ready %b required 101",
                       f.data, {done, busy, send_ready});
            end
            frames_done++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_cfg(input logic [15:0] w);
    @(negedge clk); wr_enable = 1'b1; wr_config_w = w;
    @(negedge clk); wr_enable = 1'b0;
  endtask

  // Push a frame, raise send_valid and return at the negedge after the accept edge
  task automatic send_frame(input frame_t f, input bit hold);
    int n = 0;
    exp_q.push_back(f);
    @(negedge clk); data_w = f.data; send_valid = 1'b1;
    while (!send_ready && n < 5000) begin @(negedge clk); n++; end
    if (!send_ready) begin
      n_assert++; n_fail++;
      $display("FAIL accept_timeout: got send_ready=0, required 1");
      void'(exp_q.pop_back());
      send_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) send_valid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 5000) begin @(negedge clk); n++; end
    if (frames_done < target) begin
      n_assert++; n_fail++;
      $display("FAIL frame_timeout: got %0d frames, required %0d", frames_done, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({serial_line_zeroes, serial_line_ones, busy, done, send_ready, cfg_error} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_status: got %b required 110000",
               {serial_line_zeroes, serial_line_ones, busy, done, send_ready, cfg_error});
    end
    n_assert++;
    if (r_config_w !== 16'h0010) begin
      n_fail++; $display("FAIL reset_config: got %h required 0010", r_config_w);
    end
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if (send_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b required 1", send_ready);
    end
  endtask

  task automatic test_basic();
    int done_at = 0, stop_cnt = 0, base = frames_done;
    logic [1:0] exp_v, got;
    bit chk;
    exp_q.push_back(mk(32'hA5, 8, 0, 1'b0));
    @(negedge clk); data_w = 32'hA5; send_valid = 1'b1;
    n_assert++;
    if (send_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready: got %b required 1", send_ready);
    end
    @(posedge clk);
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      got = {serial_line_zeroes, serial_line_ones};
      if (c == 1) begin
        send_valid = 1'b0;
        n_assert++;
        if ({busy, send_ready} !== 2'b10) begin
          n_fail++; $display("FAIL basic_busy: got busy/ready %b required 10", {busy, send_ready});
        end
      end
      if (got == 2'b00) stop_cnt++;
      if (done === 1'b1 && done_at == 0) done_at = c;
      chk = 1'b1;
      case (c)
        4, 13, 29:        exp_v = 2'b11;
        5, 12, 133, 140:  exp_v = 2'b10;
        21, 28:           exp_v = 2'b01;
        default: begin exp_v = 2'b11; chk = 1'b0; end
      endcase
      if (chk) begin
        n_assert++;
        if (got !== exp_v) begin
          n_fail++; $display("FAIL basic_line clock %0d: got %b required %b", c, got, exp_v);
        end
      end
    end
    n_assert++;
    if (done_at != 161) begin
      n_fail++; $display("FAIL basic_done_clock: got %0d required 161", done_at);
    end
    n_assert++;
    if (stop_cnt != 8) begin
      n_fail++; $display("FAIL basic_stop_len: got %0d required 8", stop_cnt);
    end
    wait_frames(base + 1);
  endtask

  task automatic test_long();
    int busy_cnt = 0, zlow = 0, base = frames_done;
    write_cfg(cfg_word(32, 2, 1'b0));
    n_assert++;
    if (r_config_w !== 16'h0140) begin
      n_fail++; $display("FAIL long_config: got %h required 0140", r_config_w);
    end
    send_frame(mk(32'hFFFF_FFFF, 32, 2, 1'b0), 1'b0);
    while (busy === 1'b1 && busy_cnt < 3000) begin
      busy_cnt++;
      if (serial_line_zeroes === 1'b0 && serial_line_ones === 1'b1) zlow++;
      @(negedge clk);
    end
    n_assert++;
    if (busy_cnt != 2176) begin
      n_fail++; $display("FAIL long_frame_len: got %0d required 2176", busy_cnt);
    end
    n_assert++;
    if (zlow != 0) begin
      n_fail++; $display("FAIL long_zero_pulses: got %0d required 0", zlow);
    end
    wait_frames(base + 1);
  endtask

  task automatic test_par_inv();
    int base = frames_done;
    write_cfg(cfg_word(8, 0, 1'b1));
    send_frame(mk(32'hA5, 8, 0, 1'b1), 1'b0);
    repeat (132) @(negedge clk);
    n_assert++;
    if ({serial_line_zeroes, serial_line_ones} !== 2'b01) begin
      n_fail++; $display("FAIL parinv_parity: got %b required 01", {serial_line_zeroes, serial_line_ones});
    end
    wait_frames(base + 1);
  endtask

  task automatic test_config();
    int base = frames_done;
    logic [15:0] good;
    good = r_config_w;
    write_cfg(cfg_word(7, 0, 1'b0));
    n_assert++;
    if ({cfg_error, r_config_w} !== {1'b1, good}) begin
      n_fail++; $display("FAIL cfg_len7: got err=%b cfg=%h required err=1 cfg=%h", cfg_error, r_config_w, good);
    end
    write_cfg(cfg_word(34, 0, 1'b0));
    n_assert++;
    if ({cfg_error, r_config_w} !== {1'b1, good}) begin
      n_fail++; $display("FAIL cfg_len34: got err=%b cfg=%h required err=1 cfg=%h", cfg_error, r_config_w, good);
    end
    write_cfg(cfg_word(8, 0, 1'b0));
    n_assert++;
    if ({cfg_error, r_config_w} !== {1'b0, 16'h0010}) begin
      n_fail++; $display("FAIL cfg_len8: got err=%b cfg=%h required err=0 cfg=0010", cfg_error, r_config_w);
    end
    send_frame(mk(32'h0000_5A3C, 8, 0, 1'b0), 1'b0);
    write_cfg(cfg_word(20, 0, 1'b0));
    n_assert++;
    if ({cfg_error, r_config_w} !== {1'b1, 16'h0010}) begin
      n_fail++; $display("FAIL cfg_busy_write: got err=%b cfg=%h required err=1 cfg=0010", cfg_error, r_config_w);
    end
    wait_frames(base + 1);
    write_cfg(cfg_word(20, 0, 1'b0));
    n_assert++;
    if ({cfg_error, r_config_w} !== {1'b0, 16'h0028}) begin
      n_fail++; $display("FAIL cfg_len20: got err=%b cfg=%h required err=0 cfg=0028", cfg_error, r_config_w);
    end
  endtask

  task automatic test_same_cycle();
    int base = frames_done;
    logic [31:0] d;
    d = $urandom;
    exp_q.push_back(mk(d, 16, 1, 1'b0));
    @(negedge clk);
    wr_enable = 1'b1; wr_config_w = cfg_word(16, 1, 1'b0);
    data_w = d; send_valid = 1'b1;
    @(negedge clk);
    wr_enable = 1'b0; send_valid = 1'b0;
    n_assert++;
    if ({busy, r_config_w} !== {1'b1, 16'h00A0}) begin
      n_fail++; $display("FAIL same_cycle: got busy=%b cfg=%h required busy=1 cfg=00a0", busy, r_config_w);
    end
    wait_frames(base + 1);
  endtask

  task automatic test_back_to_back();
    int base = frames_done, gap;
    logic [31:0] d [3];
    write_cfg(cfg_word(8, 0, 1'b0));
    for (int j = 0; j < 3; j++) begin
      d[j] = $urandom;
      exp_q.push_back(mk(d[j], 8, 0, 1'b0));
    end
    @(negedge clk); data_w = d[0]; send_valid = 1'b1;
    @(posedge clk);
    for (int j = 1; j < 3; j++) begin
      gap = 1;
      @(negedge clk); data_w = d[j];
      while (!send_ready && gap < 1000) begin @(negedge clk); gap++; end
      n_assert++;
      if (done !== 1'b1 || gap != 161) begin
        n_fail++; $display("FAIL b2b_accept %0d: got done=%b gap=%0d required done=1 gap=161", j, done, gap);
      end
      @(posedge clk);
    end
    @(negedge clk); send_valid = 1'b0;
    wait_frames(base + 3);
  endtask

  task automatic test_reset_mid();
    int n = 0, ab = frames_aborted, base;
    send_frame(mk(32'h0000_0001, 8, 0, 1'b0), 1'b0);
    while (serial_line_ones !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({serial_line_zeroes, serial_line_ones, busy, done, send_ready} !== 5'b11000) begin
      n_fail++; $display("FAIL reset_mid: got %b required 11000",
                         {serial_line_zeroes, serial_line_ones, busy, done, send_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if (frames_aborted != ab + 1) begin
      n_fail++; $display("FAIL reset_abort: got %0d aborted required %0d", frames_aborted, ab + 1);
    end
    base = frames_done;
    send_frame(mk($urandom, 8, 0, 1'b0), 1'b0);
    wait_frames(base + 1);
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_long();
    test_par_inv();
    test_config();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL queue_drain: got %0d left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
